// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state type, HI/LO select constants and the op decoder.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  localparam logic HorL_H = 1'b1;
  localparam logic HorL_L = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_ctl_t;

  // Accumulating codes decode as plain multiplies; the accumulate step is separate.
  function automatic op_ctl_t decode_op(input logic [2:0] op);
    op_ctl_t c;
    c.is_div    = 1'b0;
    c.is_signed = 1'b0;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB: c.is_signed = 1'b1;
      OP_DIV: begin
        c.is_div    = 1'b1;
        c.is_signed = 1'b1;
      end
      OP_DIVU: c.is_div = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic acc_t acc_mode(input logic [2:0] op);
    case (op)
      OP_MADD, OP_MADDU: return ACC_ADD;
      OP_MSUB, OP_MSUBU: return ACC_SUB;
      default:           return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add for multiply, restoring
// trial subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sh,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sh_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (sh[0] ? opnd : '0)};
    shifted = {acc, sh[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    // The remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_nxt = ge ? diff : shifted[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      sh_nxt  = {sum[0], sh[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative HI/LO multiply/divide unit, IDLE -> RUN -> FIX -> IDLE.
// Define MULDIV_MADD_EN to enable MADD/MSUB accumulation into {HI,LO}.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  input  logic             HorL,
  input  logic             MulWrite,
  output logic             Busy,
  output logic             Ready,
  output logic             DZ,
  output logic [WIDTH-1:0] DC
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
`ifdef MULDIV_MADD_EN
  acc_t             acc_mode_q, acc_mode_d;
`endif

  op_ctl_t            dec;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_acc, step_sh;
  logic [2*WIDTH-1:0] prod_mag, prod, mul_res;
  logic [WIDTH-1:0]   quo, rem;

  assign dec   = decode_op(Op);
  assign a_neg = dec.is_signed & DA[WIDTH-1];
  assign b_neg = dec.is_signed & DB[WIDTH-1];
  assign a_mag = a_neg ? -DA : DA;
  assign b_mag = b_neg ? -DB : DB;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .sh      (sh_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .sh_nxt  (step_sh)
  );

  // Sign fix-up; MIN/-1 wraps naturally back to MIN with a zero remainder.
  assign prod_mag = {acc_q, sh_q};
  assign prod     = neg_q ? -prod_mag : prod_mag;
  assign quo      = neg_q ? -sh_q : sh_q;
  assign rem      = rneg_q ? -acc_q : acc_q;

`ifdef MULDIV_MADD_EN
  always_comb begin
    case (acc_mode_q)
      ACC_ADD: mul_res = {hi_q, lo_q} + prod;
      ACC_SUB: mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ready_d   = 1'b0;
    dz_d      = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_mode_d = acc_mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          is_div_d  = dec.is_div;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          acc_d     = '0;
          cnt_d     = CW'(WIDTH);
          sh_d      = dec.is_div ? a_mag : b_mag;
          opnd_d    = dec.is_div ? b_mag : a_mag;
          dz_pend_d = dec.is_div && (DB == '0);
`ifdef MULDIV_MADD_EN
          acc_mode_d = acc_mode(Op);
`endif
          state_d   = (dec.is_div && (DB == '0)) ? ST_FIX : ST_RUN;
        end else if (MulWrite) begin
          if (HorL == HorL_H) hi_d = DA;
          else                lo_d = DA;
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        dz_d    = dz_pend_q;
        if (!dz_pend_q) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are cleared along with control so post-reset state is fully known.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
      dz_q      <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_mode_q <= ACC_NONE;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ready_q   <= ready_d;
      dz_q      <= dz_d;
`ifdef MULDIV_MADD_EN
      acc_mode_q <= acc_mode_d;
`endif
    end
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Ready = ready_q;
  assign DZ    = dz_q;
  assign DC    = (HorL == HorL_L) ? lo_q : hi_q;

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter WIDTH SHALL default to 32; operand, HI and LO width; legal values 8..64, even.
REQ-002 Clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to launch an operation; accepted only when Busy=0.
REQ-005 Op  input  3  operation code (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU).
REQ-006 DA  input  WIDTH  multiplicand, dividend, or MulWrite data.
REQ-007 DB  input  WIDTH  multiplier or divisor.
REQ-008 HorL  input  1  read/write select: 1=HI, 0=LO.
REQ-009 MulWrite  input  1  write DA into HI or LO, as selected by HorL (MTHI/MTLO).
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Ready  output  1  one-cycle pulse when the HI/LO result is committed.
REQ-012 DZ  output  1  divide-by-zero flag; valid while Ready=1.
REQ-013 DC  output  WIDTH  combinational read of HI (HorL=1) or LO (HorL=0).

Function
REQ-014 State machine SHALL be IDLE -> RUN -> FIX -> IDLE; Busy=1 in RUN and in FIX.
REQ-015 Start with Busy=0 at edge E0 SHALL latch operands and the sign flags, load the iteration counter with WIDTH, and enter RUN.
REQ-016 RUN SHALL perform one radix-2 step per cycle for exactly WIDTH cycles (shift-add for multiply; restoring subtract for divide) on magnitudes.
REQ-017 FIX SHALL apply the sign correction, write HI/LO, and return to IDLE; Ready SHALL be high during the cycle after that write, so Ready is first seen WIDTH+2 cycles after E0.
REQ-018 Signed ops SHALL negate operands whose MSB is 1; unsigned ops SHALL take operands as-is.
REQ-019 Multiply SHALL set {HI,LO} to the 2*WIDTH-bit product; the product SHALL be negated when the operand signs differ (signed ops only).
REQ-020 Divide SHALL set LO to the quotient, truncated toward zero, and HI to the remainder; the remainder sign SHALL equal the dividend sign.
REQ-021 Signed MIN/-1 SHALL yield LO=MIN and HI=0 with no flag.
REQ-022 DB=0 on DIV/DIVU SHALL skip RUN (IDLE -> FIX); HI/LO SHALL be left unchanged, and Ready and DZ SHALL both pulse 2 cycles after E0.
REQ-023 DZ SHALL be 0 whenever Ready=0 and for every non-divide op.
REQ-024 Start while Busy=1 SHALL be ignored, with no queueing.
REQ-025 MulWrite with Busy=0 and Start=0 SHALL write DA into the register selected by HorL at the edge.
REQ-026 MulWrite with Busy=1 or with Start=1 SHALL be ignored; Start SHALL win.
REQ-027 DC SHALL show the old HI/LO until the commit edge and the new value from the cycle Ready=1.
REQ-028 Undefined Op codes SHALL be treated as MULTU.

Reset
REQ-029 Reset SHALL force state=IDLE, HI=LO=0, Busy=0, Ready=0, DZ=0, and the counter and datapath registers to 0.
REQ-030 Reset in mid-operation SHALL abort the operation with no HI/LO commit and no Ready pulse; Reset SHALL take priority over Start and MulWrite.

Configuration
REQ-031 With macro MULDIV_MADD_EN defined, MADD/MADDU SHALL commit {HI,LO}+product and MSUB/MSUBU SHALL commit {HI,LO}-product, modulo 2^(2*WIDTH), in FIX.
REQ-032 Without MULDIV_MADD_EN, MADD/MSUB codes SHALL behave as MULT and MADDU/MSUBU codes as MULTU, and no accumulate adder SHALL be synthesized.

Structure
REQ-033 Package muldiv_pkg SHALL hold the Op encodings, the state enum typedef, and the HorL_H/HorL_L constants.
REQ-034 Sub-module muldiv_step SHALL implement the combinational single-iteration datapath (add/shift or trial subtract), instantiated once.

Verification
REQ-035 WIDTH=32: MULT DA=-3, DB=7 -> Ready 34 cycles after Start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 DIV DA=-7, DB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), DZ=0; DIVU DA=7, DB=2 -> LO=3, HI=1.
REQ-037 DIVU DA=5, DB=0 with HI=0x11, LO=0x22 -> Ready and DZ high 2 cycles after Start; HI/LO unchanged.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF; second Start at cycle 5; MulWrite at cycle 10 -> only the first op runs; HI=0xFFFFFFFE, LO=1.
REQ-039 Reset at cycle 15 of a DIV -> Busy=0, no Ready pulse, HI=LO=0; a following MulWrite HorL=1 DA=0xABCD -> DC=0xABCD.
REQ-040 MULTU 2*3 then MADD 2*3 under MULDIV_MADD_EN -> LO=12; the same sequence without MULDIV_MADD_EN -> LO=6.
